// File: rtl/draw_game_objects_if.sv
// -----------------------------------------------------------------------------
// vga_intf
//   Bundle of VGA raster timing plus pixel colour passed between pipeline
//   stages of the graphics path.
//   Signals:
//     hcount, vcount : current pixel coordinates (W bits)
//     hsync, vsync   : sync pulses
//     hblnk, vblnk   : blanking flags
//     rgb            : 12-bit pixel colour (4:4:4)
//   Modports:
//     in  : consumer view (all inputs)
//     out : producer view (all outputs)
// -----------------------------------------------------------------------------
interface vga_intf #(
  parameter int W = 11
);
  logic [W-1:0] hcount;
  logic [W-1:0] vcount;
  logic         hsync;
  logic         vsync;
  logic         hblnk;
  logic         vblnk;
  logic [11:0]  rgb;

  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_game_objects.sv
// -----------------------------------------------------------------------------
// draw_game_objects
//   Overlays the round ball and the two paddles on the game field video.
//   Object positions are double-buffered (pending -> active at frame start)
//   to avoid tearing; a hit strobe flashes the ball colour for FLASH_FRAMES
//   frames. Output is the input raster delayed by two clocks.
//   Ports:
//     clk            : pixel clock
//     rst            : asynchronous active-low reset
//     x_ball, y_ball : ball bounding-box top-left corner
//     y_pad_left     : left paddle top edge
//     y_pad_right    : right paddle top edge
//     pos_valid      : strobe, captures the four positions as pending
//     hit            : strobe, starts/restarts the ball flash
//     game_field_in  : upstream raster timing and rgb
//     game_field_out : same raster, 2 clk later, with objects drawn
// -----------------------------------------------------------------------------
module draw_game_objects #(
  parameter int          COORD_W      = 11,
  parameter int          BALL_SCALE   = 1,
  parameter int          PAD_WIDTH    = 16,
  parameter int          PAD_HEIGHT   = 146,
  parameter int          X_PAD_LEFT   = 30,
  parameter int          X_PAD_RIGHT  = 979,
  parameter logic [11:0] BALL_RGB     = 12'hFFF,
  parameter logic [11:0] FLASH_RGB    = 12'hF00,
  parameter logic [11:0] PAD_RGB      = 12'hFFF,
  parameter int          FLASH_FRAMES = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] x_ball,
  input  logic [COORD_W-1:0] y_ball,
  input  logic [COORD_W-1:0] y_pad_left,
  input  logic [COORD_W-1:0] y_pad_right,
  input  logic               pos_valid,
  input  logic               hit,
  vga_intf.in                game_field_in,
  vga_intf.out               game_field_out
);

  localparam int LOG2S     = (BALL_SCALE == 4) ? 2 : (BALL_SCALE == 2) ? 1 : 0;
  localparam int BALL_SIDE = 16 << LOG2S;
  // One extra bit so boxes touching the far edge never wrap to low coordinates
  localparam int EW        = COORD_W + 1;

  localparam logic [COORD_W-1:0] X_BALL_RST = COORD_W'((1024 - BALL_SIDE) / 2);
  localparam logic [COORD_W-1:0] Y_BALL_RST = COORD_W'((768 - BALL_SIDE) / 2);
  localparam logic [COORD_W-1:0] Y_PAD_RST  = COORD_W'(312);

  localparam logic [EW-1:0] X_PAD_L = EW'(X_PAD_LEFT);
  localparam logic [EW-1:0] X_PAD_R = EW'(X_PAD_RIGHT);
  localparam logic [EW-1:0] PAD_W_M1 = EW'(PAD_WIDTH - 1);
  localparam logic [EW-1:0] PAD_H_M1 = EW'(PAD_HEIGHT - 1);
  localparam logic [EW-1:0] BALL_M1  = EW'(BALL_SIDE - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_FLASH = 1'b1;
  localparam logic [7:0] FLASH_LOAD = 8'(FLASH_FRAMES);

  // Circle bitmap, bit 15 is the leftmost pixel of a row
  function automatic logic [15:0] ballRow(input logic [3:0] row);
    case (row)
      4'd0:    ballRow = 16'h0000;
      4'd1:    ballRow = 16'h0380;
      4'd2:    ballRow = 16'h07C0;
      4'd3:    ballRow = 16'h0FE0;
      4'd4:    ballRow = 16'h1FF0;
      4'd5:    ballRow = 16'h3FF8;
      4'd6:    ballRow = 16'h7FFC;
      4'd7:    ballRow = 16'hFFFE;
      4'd8:    ballRow = 16'hFFFE;
      4'd9:    ballRow = 16'hFFFE;
      4'd10:   ballRow = 16'h7FFC;
      4'd11:   ballRow = 16'h3FF8;
      4'd12:   ballRow = 16'h1FF0;
      4'd13:   ballRow = 16'h0FE0;
      4'd14:   ballRow = 16'h07C0;
      default: ballRow = 16'h0380;
    endcase
  endfunction

  logic [COORD_W-1:0] r_pend_x, r_pend_y, r_pend_pl, r_pend_pr;
  logic [COORD_W-1:0] r_act_x, r_act_y, r_act_pl, r_act_pr;
  logic               r_vblnk_d;
  logic [0:0]         r_state;
  logic [7:0]         r_cnt;

  logic [COORD_W-1:0] r1_hcount, r1_vcount, r2_hcount, r2_vcount;
  logic               r1_hsync, r1_vsync, r1_hblnk, r1_vblnk;
  logic               r2_hsync, r2_vsync, r2_hblnk, r2_vblnk;
  logic [11:0]        r1_rgb, r2_rgb;

  logic          w_frame_start;
  logic [EW-1:0] w_h, w_v, w_bx, w_by, w_pl, w_pr, w_dx, w_dy;
  logic [3:0]    w_row, w_col;
  logic [15:0]   w_rom_bits;
  logic          w_in_ball, w_ball_px, w_pad_l, w_pad_r;
  logic [11:0]   w_rgb_nxt;

  assign w_frame_start = game_field_in.vblnk & ~r_vblnk_d;

  // Pending set follows pos_valid; active set only changes at frame start,
  // so a coincident pos_valid lands in the active set one frame later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend_x  <= X_BALL_RST;
      r_pend_y  <= Y_BALL_RST;
      r_pend_pl <= Y_PAD_RST;
      r_pend_pr <= Y_PAD_RST;
      r_act_x   <= X_BALL_RST;
      r_act_y   <= Y_BALL_RST;
      r_act_pl  <= Y_PAD_RST;
      r_act_pr  <= Y_PAD_RST;
      r_vblnk_d <= 1'b0;
    end else begin
      r_vblnk_d <= game_field_in.vblnk;
      if (pos_valid) begin
        r_pend_x  <= x_ball;
        r_pend_y  <= y_ball;
        r_pend_pl <= y_pad_left;
        r_pend_pr <= y_pad_right;
      end
      if (w_frame_start) begin
        r_act_x  <= r_pend_x;
        r_act_y  <= r_pend_y;
        r_act_pl <= r_pend_pl;
        r_act_pr <= r_pend_pr;
      end
    end
  end

  // Flash FSM: hit (re)loads the frame counter and wins over a coincident
  // frame start; each frame start in FLASH consumes one frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 8'd0;
    end else if (hit) begin
      r_state <= ST_FLASH;
      r_cnt   <= FLASH_LOAD;
    end else if (r_state == ST_FLASH && w_frame_start) begin
      if (r_cnt <= 8'd1) begin
        r_state <= ST_IDLE;
        r_cnt   <= 8'd0;
      end else begin
        r_cnt <= r_cnt - 8'd1;
      end
    end
  end

  assign w_h  = {1'b0, game_field_in.hcount};
  assign w_v  = {1'b0, game_field_in.vcount};
  assign w_bx = {1'b0, r_act_x};
  assign w_by = {1'b0, r_act_y};
  assign w_pl = {1'b0, r_act_pl};
  assign w_pr = {1'b0, r_act_pr};
  assign w_dx = w_h - w_bx;
  assign w_dy = w_v - w_by;

  assign w_row      = 4'(w_dy >> LOG2S);
  assign w_col      = 4'(w_dx >> LOG2S);
  assign w_rom_bits = ballRow(w_row);
  assign w_in_ball  = (w_h >= w_bx) && (w_h <= w_bx + BALL_M1) &&
                      (w_v >= w_by) && (w_v <= w_by + BALL_M1);
  assign w_ball_px  = w_in_ball && w_rom_bits[4'd15 - w_col];

  assign w_pad_l = (w_h >= X_PAD_L) && (w_h <= X_PAD_L + PAD_W_M1) &&
                   (w_v >= w_pl) && (w_v <= w_pl + PAD_H_M1);
  assign w_pad_r = (w_h >= X_PAD_R) && (w_h <= X_PAD_R + PAD_W_M1) &&
                   (w_v >= w_pr) && (w_v <= w_pr + PAD_H_M1);

  // Blanking beats the ball, the ball beats the paddles
  always_comb begin
    w_rgb_nxt = game_field_in.rgb;
    if (game_field_in.hblnk || game_field_in.vblnk) begin
      w_rgb_nxt = 12'h000;
    end else if (w_ball_px) begin
      w_rgb_nxt = (r_state == ST_FLASH) ? FLASH_RGB : BALL_RGB;
    end else if (w_pad_l || w_pad_r) begin
      w_rgb_nxt = PAD_RGB;
    end
  end

  // Two register stages keep rgb aligned with all timing signals
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r1_hcount <= '0;
      r1_vcount <= '0;
      r1_hsync  <= 1'b0;
      r1_vsync  <= 1'b0;
      r1_hblnk  <= 1'b0;
      r1_vblnk  <= 1'b0;
      r1_rgb    <= 12'h000;
      r2_hcount <= '0;
      r2_vcount <= '0;
      r2_hsync  <= 1'b0;
      r2_vsync  <= 1'b0;
      r2_hblnk  <= 1'b0;
      r2_vblnk  <= 1'b0;
      r2_rgb    <= 12'h000;
    end else begin
      r1_hcount <= game_field_in.hcount;
      r1_vcount <= game_field_in.vcount;
      r1_hsync  <= game_field_in.hsync;
      r1_vsync  <= game_field_in.vsync;
      r1_hblnk  <= game_field_in.hblnk;
      r1_vblnk  <= game_field_in.vblnk;
      r1_rgb    <= w_rgb_nxt;
      r2_hcount <= r1_hcount;
      r2_vcount <= r1_vcount;
      r2_hsync  <= r1_hsync;
      r2_vsync  <= r1_vsync;
      r2_hblnk  <= r1_hblnk;
      r2_vblnk  <= r1_vblnk;
      r2_rgb    <= r1_rgb;
    end
  end

  assign game_field_out.hcount = r2_hcount;
  assign game_field_out.vcount = r2_vcount;
  assign game_field_out.hsync  = r2_hsync;
  assign game_field_out.vsync  = r2_vsync;
  assign game_field_out.hblnk  = r2_hblnk;
  assign game_field_out.vblnk  = r2_vblnk;
  assign game_field_out.rgb    = r2_rgb;

endmodule
